// File: rtl/divider_pkg.sv
// Shared types for the iterative divider: FSM state encoding and default geometry.
package divider_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE  = 3'd0,
    DIV_LOAD  = 3'd1,
    DIV_RUN   = 3'd2,
    DIV_FIXUP = 3'd3,
    DIV_ZERO  = 3'd4
  } div_state_e;

  localparam int DIV_WIDTH    = 32;
  localparam int DIV_CNT_BITS = 5;

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference if it did not borrow.
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             qbit_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Full WIDTH+1 bit shift: an unsigned divisor near 2^WIDTH lets the remainder reach the msb.
  assign shifted = {rem_i, msb_i};
  assign trial   = shifted - {1'b0, divisor_i};
  assign qbit_o  = ~trial[WIDTH];
  assign rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Multi-cycle signed/unsigned integer divider for the execute stage (l.div / l.divu).
// Operands are latched as magnitudes on accept; signs are reapplied in FIXUP.
//
// state     | meaning
// DIV_IDLE  | waiting for start; outputs hold last results
// DIV_LOAD  | clear partial remainder, arm iteration counter
// DIV_RUN   | one shift-subtract step per cycle, WIDTH cycles
// DIV_FIXUP | apply quotient/remainder signs, publish results, pulse done
// DIV_ZERO  | divide-by-zero: publish fixed results, pulse done
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH    = DIV_WIDTH,
  parameter int CNT_BITS = DIV_CNT_BITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] operantA,
  input  logic [WIDTH-1:0] operantB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divideByZero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend, becomes quotient as bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic negq_q, negq_d;
  logic negr_q, negr_d;
  logic minus1_q, minus1_d;
  logic done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic dbz_q, dbz_d;
  logic ovf_q, ovf_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             step_qbit;
  logic [WIDTH-1:0] step_rem;

  assign a_mag = (isSigned && operantA[WIDTH-1]) ? -operantA : operantA;
  assign b_mag = (isSigned && operantB[WIDTH-1]) ? -operantB : operantB;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .msb_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .qbit_o    (step_qbit),
    .rem_o     (step_rem)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    minus1_d = minus1_q;
    done_d   = 1'b0;
    quo_d    = quo_q;
    rmd_d    = rmd_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          negq_d   = isSigned & (operantA[WIDTH-1] ^ operantB[WIDTH-1]);
          negr_d   = isSigned & operantA[WIDTH-1];
          minus1_d = isSigned & (operantA == MIN_VAL) & (&operantB);
          dvs_d    = b_mag;
          if (operantB == '0) begin
            dvd_d   = operantA;
            state_d = DIV_ZERO;
          end else begin
            dvd_d   = a_mag;
            state_d = DIV_LOAD;
          end
        end
      end
      DIV_LOAD: begin
        rem_d   = '0;
        cnt_d   = CNT_BITS'(WIDTH-1);
        state_d = DIV_RUN;
      end
      DIV_RUN: begin
        dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
        rem_d = step_rem;
        if (cnt_q == '0) begin
          state_d = DIV_FIXUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV_FIXUP: begin
        // MIN/-1 needs no special path: |MIN| divided by 1 already yields MIN, remainder 0.
        quo_d   = negq_q ? -dvd_q : dvd_q;
        rmd_d   = negr_q ? -rem_q : rem_q;
        dbz_d   = 1'b0;
        ovf_d   = minus1_q;
        done_d  = 1'b1;
        state_d = DIV_IDLE;
      end
      DIV_ZERO: begin
        quo_d   = '0;
        rmd_d   = dvd_q;
        dbz_d   = 1'b1;
        ovf_d   = 1'b1;
        done_d  = 1'b1;
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      minus1_q <= 1'b0;
      done_q   <= 1'b0;
      quo_q    <= '0;
      rmd_q    <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      minus1_q <= minus1_d;
      done_q   <= done_d;
      quo_q    <= quo_d;
      rmd_q    <= rmd_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy         = (state_q != DIV_IDLE);
  assign done         = done_q;
  assign quotient     = quo_q;
  assign remainder    = rmd_q;
  assign divideByZero = dbz_q;
  assign overflow     = ovf_q;

endmodule
